// File: rtl/seq_combolock_if.sv
// seq_combolock_if: keypad-side and status-side signals of the combination lock.
//   master : keypad/debouncer side (drives digit strobes and commands, reads status)
//   slave  : lock core side
//   Inputs to core : digit_valid, digit_in, clear, lock_cmd, prog_cmd
//   Outputs of core: unlocked, programming, locked_out, alarm,
//                    attempts_left, digit_count, entry_ok, entry_bad
interface seq_combolock_if #(
  parameter int DIGIT_W      = 4,
  parameter int NUM_DIGITS   = 4,
  parameter int MAX_ATTEMPTS = 3
);
  localparam int AW = $clog2(MAX_ATTEMPTS + 1);
  localparam int CW = $clog2(NUM_DIGITS + 1);

  logic               digit_valid;
  logic [DIGIT_W-1:0] digit_in;
  logic               clear;
  logic               lock_cmd;
  logic               prog_cmd;
  logic               unlocked;
  logic               programming;
  logic               locked_out;
  logic               alarm;
  logic [AW-1:0]      attempts_left;
  logic [CW-1:0]      digit_count;
  logic               entry_ok;
  logic               entry_bad;

  modport master (
    output digit_valid, digit_in, clear, lock_cmd, prog_cmd,
    input  unlocked, programming, locked_out, alarm,
           attempts_left, digit_count, entry_ok, entry_bad
  );

  modport slave (
    input  digit_valid, digit_in, clear, lock_cmd, prog_cmd,
    output unlocked, programming, locked_out, alarm,
           attempts_left, digit_count, entry_ok, entry_bad
  );
endinterface

// File: rtl/seq_combolock.sv
// seq_combolock: multi-digit combination lock with attempt counting, timed
// lockout, latched alarm and a reprogrammable code register.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : seq_combolock_if.slave (digit strobes, commands, status outputs)
module seq_combolock #(
  parameter int DIGIT_W        = 4,
  parameter int NUM_DIGITS     = 4,
  parameter logic [DIGIT_W*NUM_DIGITS-1:0] DEFAULT_CODE = 16'h1234,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int ALARM_LOCKOUTS = 2
) (
  input logic clk,
  input logic rst,
  seq_combolock_if.slave bus
);
  localparam int CODE_W = DIGIT_W * NUM_DIGITS;
  localparam int AW     = $clog2(MAX_ATTEMPTS + 1);
  localparam int CW     = $clog2(NUM_DIGITS + 1);
  localparam int TW     = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int LW     = $clog2(ALARM_LOCKOUTS + 1);

  typedef enum logic [2:0] {
    S_ENTRY, S_OPEN, S_PROGRAM, S_LOCKOUT, S_ALARM
  } state_t;

  state_t            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] buf_q, buf_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     att_q, att_d;
  logic [LW-1:0]     lock_q, lock_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic              ok_q, ok_d;
  logic              bad_q, bad_d;

  logic [CODE_W-1:0] entry;
  logic              last;
  logic [LW-1:0]     lock_inc;

  // Shift form keeps NUM_DIGITS=1 legal (no zero-width buffer slice).
  assign entry    = (buf_q << DIGIT_W) | CODE_W'(bus.digit_in);
  assign last     = (cnt_q == CW'(NUM_DIGITS - 1));
  assign lock_inc = lock_q + LW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ENTRY;
      code_q  <= DEFAULT_CODE;
      buf_q   <= '0;
      cnt_q   <= '0;
      att_q   <= AW'(MAX_ATTEMPTS);
      lock_q  <= '0;
      tmr_q   <= '0;
      ok_q    <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      att_q   <= att_d;
      lock_q  <= lock_d;
      tmr_q   <= tmr_d;
      ok_q    <= ok_d;
      bad_q   <= bad_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    att_d   = att_q;
    lock_d  = lock_q;
    tmr_d   = tmr_q;
    ok_d    = 1'b0;
    bad_d   = 1'b0;
    case (state_q)
      S_ENTRY: begin
        if (bus.clear) begin
          cnt_d = '0;
          buf_d = '0;
        end else if (bus.digit_valid) begin
          if (last) begin
            cnt_d = '0;
            buf_d = '0;
            if (entry == code_q) begin
              state_d = S_OPEN;
              ok_d    = 1'b1;
              att_d   = AW'(MAX_ATTEMPTS);
              lock_d  = '0;
            end else begin
              bad_d = 1'b1;
              if (att_q > AW'(1)) begin
                att_d = att_q - AW'(1);
              end else begin
                att_d  = '0;
                lock_d = lock_inc;
                if (lock_inc == LW'(ALARM_LOCKOUTS)) begin
                  state_d = S_ALARM;
                end else begin
                  state_d = S_LOCKOUT;
                  tmr_d   = TW'(LOCKOUT_CYCLES - 1);
                end
              end
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
            buf_d = entry;
          end
        end
      end
      S_LOCKOUT: begin
        if (tmr_q == '0) begin
          state_d = S_ENTRY;
          att_d   = AW'(MAX_ATTEMPTS);
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_ALARM: begin
      end
      S_OPEN: begin
        if (bus.lock_cmd) begin
          state_d = S_ENTRY;
          att_d   = AW'(MAX_ATTEMPTS);
          cnt_d   = '0;
          buf_d   = '0;
        end else if (bus.prog_cmd) begin
          state_d = S_PROGRAM;
          cnt_d   = '0;
          buf_d   = '0;
        end
      end
      S_PROGRAM: begin
        if (bus.clear) begin
          state_d = S_OPEN;
          cnt_d   = '0;
          buf_d   = '0;
        end else if (bus.digit_valid) begin
          if (last) begin
            code_d  = entry;
            state_d = S_ENTRY;
            att_d   = AW'(MAX_ATTEMPTS);
            cnt_d   = '0;
            buf_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
            buf_d = entry;
          end
        end
      end
      default: state_d = S_ENTRY;
    endcase
  end

  assign bus.unlocked      = (state_q == S_OPEN);
  assign bus.programming   = (state_q == S_PROGRAM);
  assign bus.locked_out    = (state_q == S_LOCKOUT);
  assign bus.alarm         = (state_q == S_ALARM);
  assign bus.attempts_left = att_q;
  assign bus.digit_count   = cnt_q;
  assign bus.entry_ok      = ok_q;
  assign bus.entry_bad     = bad_q;
endmodule

// File: tb/tb_seq_combolock.sv
// tb_seq_combolock: directed-vector bench; expected entry results are queued
// by the stimulus and consumed by a monitor on every entry_ok/entry_bad pulse.
module tb_seq_combolock;
  logic clk = 1'b0;
  logic rst = 1'b1;

  seq_combolock_if #(.DIGIT_W(4), .NUM_DIGITS(4), .MAX_ATTEMPTS(3)) bus ();

  seq_combolock #(
    .DIGIT_W(4), .NUM_DIGITS(4), .DEFAULT_CODE(16'h1234),
    .MAX_ATTEMPTS(3), .LOCKOUT_CYCLES(16), .ALARM_LOCKOUTS(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ok;
    logic       bad;
    logic [1:0] att;
    logic       unl;
    logic       lo;
    logic       al;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: each result pulse consumes one queued expectation.
  always @(negedge clk) begin
    if (!rst && (bus.entry_ok || bus.entry_bad)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_ok",    int'(bus.entry_ok),      int'(e.ok));
        chk("pulse_bad",   int'(bus.entry_bad),     int'(e.bad));
        chk("pulse_att",   int'(bus.attempts_left), int'(e.att));
        chk("pulse_open",  int'(bus.unlocked),      int'(e.unl));
        chk("pulse_lock",  int'(bus.locked_out),    int'(e.lo));
        chk("pulse_alarm", int'(bus.alarm),         int'(e.al));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  localparam exp_t OK3  = '{ok:1'b1, bad:1'b0, att:2'd3, unl:1'b1, lo:1'b0, al:1'b0};
  localparam exp_t BAD2 = '{ok:1'b0, bad:1'b1, att:2'd2, unl:1'b0, lo:1'b0, al:1'b0};
  localparam exp_t BAD1 = '{ok:1'b0, bad:1'b1, att:2'd1, unl:1'b0, lo:1'b0, al:1'b0};
  localparam exp_t BADL = '{ok:1'b0, bad:1'b1, att:2'd0, unl:1'b0, lo:1'b1, al:1'b0};
  localparam exp_t BADA = '{ok:1'b0, bad:1'b1, att:2'd0, unl:1'b0, lo:1'b0, al:1'b1};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    bus.digit_valid = 1'b1;
    bus.digit_in    = d;
    cyc();
    bus.digit_valid = 1'b0;
  endtask

  task automatic enter4(input logic [15:0] code, input bit push, input exp_t e);
    for (int i = 0; i < 4; i++) begin
      if (i == 3 && push) exp_q.push_back(e);
      press(code[15-4*i -: 4]);
    end
  endtask

  task automatic pulse_lock();
    bus.lock_cmd = 1'b1;
    cyc();
    bus.lock_cmd = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Counts cycles with locked_out high, optionally strobing a digit midway.
  task automatic run_lockout(input bit strobe, output int n);
    n = 0;
    while (bus.locked_out && n < 40) begin
      n++;
      if (strobe && n == 5) begin
        bus.digit_valid = 1'b1;
        bus.digit_in    = 4'd1;
      end
      cyc();
      bus.digit_valid = 1'b0;
      if (strobe && n == 5) chk("lockout_digit_count", int'(bus.digit_count), 0);
    end
  endtask

  initial begin
    int n;
    int alarm_low;
    bus.digit_valid = 1'b0;
    bus.digit_in    = '0;
    bus.clear       = 1'b0;
    bus.lock_cmd    = 1'b0;
    bus.prog_cmd    = 1'b0;
    do_reset();
    chk("rst_open",  int'(bus.unlocked),      0);
    chk("rst_prog",  int'(bus.programming),   0);
    chk("rst_lock",  int'(bus.locked_out),    0);
    chk("rst_alarm", int'(bus.alarm),         0);
    chk("rst_att",   int'(bus.attempts_left), 3);
    chk("rst_dc",    int'(bus.digit_count),   0);
    chk("rst_ok",    int'(bus.entry_ok),      0);
    chk("rst_bad",   int'(bus.entry_bad),     0);

    // 1: correct default code
    press(4'd1);
    chk("dc_after_one", int'(bus.digit_count), 1);
    press(4'd2);
    press(4'd3);
    exp_q.push_back(OK3);
    press(4'd4);
    chk("dc_after_full", int'(bus.digit_count), 0);
    cyc();
    chk("ok_one_cycle", int'(bus.entry_ok), 0);
    chk("still_open", int'(bus.unlocked), 1);
    pulse_lock();
    chk("relock_open", int'(bus.unlocked), 0);

    // 2 + 3: wrong entries down to lockout
    enter4(16'h1235, 1'b1, BAD2);
    enter4(16'h9999, 1'b1, BAD1);
    chk("bad_not_open", int'(bus.unlocked), 0);
    enter4(16'h0000, 1'b1, BADL);
    run_lockout(1'b1, n);
    chk("lockout_len", n, 16);
    chk("post_lock_att", int'(bus.attempts_left), 3);
    chk("post_lock_dc",  int'(bus.digit_count), 0);
    enter4(16'h1234, 1'b1, OK3);
    pulse_lock();

    // 4: two lockouts -> alarm
    enter4(16'h1111, 1'b1, BAD2);
    enter4(16'h2222, 1'b1, BAD1);
    enter4(16'h3333, 1'b1, BADL);
    run_lockout(1'b0, n);
    chk("lockout2_len", n, 16);
    enter4(16'h4444, 1'b1, BAD2);
    enter4(16'h5555, 1'b1, BAD1);
    enter4(16'h6666, 1'b1, BADA);
    alarm_low = 0;
    for (int i = 0; i < 100; i++) begin
      bus.digit_valid = 1'($urandom);
      bus.digit_in    = 4'($urandom);
      bus.clear       = 1'($urandom);
      bus.lock_cmd    = 1'($urandom);
      bus.prog_cmd    = 1'($urandom);
      cyc();
      if (!bus.alarm) alarm_low++;
    end
    bus.digit_valid = 1'b0;
    bus.clear       = 1'b0;
    bus.lock_cmd    = 1'b0;
    bus.prog_cmd    = 1'b0;
    chk("alarm_held_cycles_low", alarm_low, 0);
    chk("alarm_att", int'(bus.attempts_left), 0);
    do_reset();
    chk("alarm_rst_alarm", int'(bus.alarm), 0);
    chk("alarm_rst_att",   int'(bus.attempts_left), 3);

    // 5: reprogram to 7701
    enter4(16'h1234, 1'b1, OK3);
    bus.prog_cmd = 1'b1;
    cyc();
    bus.prog_cmd = 1'b0;
    chk("prog_mode", int'(bus.programming), 1);
    enter4(16'h7701, 1'b0, OK3);
    chk("prog_done_prog", int'(bus.programming), 0);
    chk("prog_done_open", int'(bus.unlocked), 0);
    chk("prog_done_att",  int'(bus.attempts_left), 3);
    enter4(16'h1234, 1'b1, BAD2);
    enter4(16'h7701, 1'b1, OK3);

    // lock and prog together from OPEN: lock wins
    bus.lock_cmd = 1'b1;
    bus.prog_cmd = 1'b1;
    cyc();
    bus.lock_cmd = 1'b0;
    bus.prog_cmd = 1'b0;
    chk("lockprog_open", int'(bus.unlocked), 0);
    chk("lockprog_prog", int'(bus.programming), 0);

    // 6: clear beats digit_valid; PROGRAM abort keeps code
    do_reset();
    press(4'd1);
    press(4'd2);
    bus.clear = 1'b1;
    press(4'd3);
    bus.clear = 1'b0;
    chk("clear_dc",  int'(bus.digit_count), 0);
    chk("clear_att", int'(bus.attempts_left), 3);
    enter4(16'h1234, 1'b1, OK3);
    bus.prog_cmd = 1'b1;
    cyc();
    bus.prog_cmd = 1'b0;
    press(4'd5);
    chk("prog_dc", int'(bus.digit_count), 1);
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
    chk("abort_open", int'(bus.unlocked), 1);
    chk("abort_prog", int'(bus.programming), 0);
    chk("abort_dc",   int'(bus.digit_count), 0);
    pulse_lock();
    enter4(16'h1234, 1'b1, OK3);

    cyc();
    cyc();
    chk("pending_pulses", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
